// File: rtl/dekatron_step_sequencer_if.sv
// Request/status bundle between a sequencing controller and the dekatron
// step sequencer. The controller side is the master; the sequencer is the slave.
//
// Handshake: Start is a request that is taken only in a cycle where Ready=1
// (Start and Ready both high at a rising edge). Dec and Steps are captured in
// that same cycle. While Busy=1, Start, Dec and Steps are ignored. Completion
// is the one-cycle Done pulse, with Aborted valid alongside it.
interface dekatron_step_sequencer_if #(
  parameter int COUNT_WIDTH = 4
);
  logic                   Start;
  logic                   Dec;
  logic [COUNT_WIDTH-1:0] Steps;
  logic                   Abort;
  logic [1:0]             PulsesOut;
  logic                   Busy;
  logic                   Ready;
  logic                   Done;
  logic                   Aborted;
  logic                   StepStrobe;
  logic [COUNT_WIDTH-1:0] StepsLeft;
  logic [1:0]             state_dbg;

  modport master (
    output Start, Dec, Steps, Abort,
    input  PulsesOut, Busy, Ready, Done, Aborted, StepStrobe, StepsLeft, state_dbg
  );

  modport slave (
    input  Start, Dec, Steps, Abort,
    output PulsesOut, Busy, Ready, Done, Aborted, StepStrobe, StepsLeft, state_dbg
  );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// Drives a dekatron guide pair through a requested number of steps.
// Each step is PHASE_A, PHASE_B (PULSE_CYCLES each) then an optional idle GAP.
// Guide outputs are decoded from state only, so inputs never reach PulsesOut
// combinationally. An abort lets the step in progress finish so the glow is
// always left resting on a main cathode.
module dekatron_step_sequencer #(
  parameter int COUNT_WIDTH  = 4,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input logic                      Clk,
  input logic                      Rst_n,
  dekatron_step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PHASE_A = 2'd1,
    PHASE_B = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Phase counter only needs to reach the longest phase length minus one.
  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_t                 state, state_next;
  logic [CW-1:0]          cnt;
  logic                   dec_q;
  logic [COUNT_WIDTH-1:0] steps_left;
  logic                   abort_pending;
  logic                   done_q;
  logic                   aborted_q;

  logic accept, run, abort_now, more, cont, step_end, finishing;
  logic [1:0] pulses;

  assign accept    = (state == IDLE) && bus.Start;
  assign run       = accept && (bus.Steps != '0);
  assign abort_now = abort_pending || bus.Abort;
  assign more      = (steps_left > COUNT_WIDTH'(1));
  assign cont      = more && !abort_now;
  assign finishing = (state != IDLE) && (state_next == IDLE);

  // Next-state, step-end strobe and guide decode.
  always_comb begin
    state_next = state;
    step_end   = 1'b0;
    pulses     = 2'b00;
    case (state)
      IDLE: begin
        if (run) state_next = PHASE_A;
      end
      PHASE_A: begin
        pulses = dec_q ? 2'b10 : 2'b01;
        if (cnt == P_LAST) state_next = PHASE_B;
      end
      PHASE_B: begin
        pulses = dec_q ? 2'b01 : 2'b10;
        if (cnt == P_LAST) begin
          if (HAS_GAP) begin
            state_next = GAP;
          end else begin
            step_end   = 1'b1;
            state_next = cont ? PHASE_A : IDLE;
          end
        end
      end
      GAP: begin
        if (cnt == G_LAST) begin
          step_end   = 1'b1;
          state_next = cont ? PHASE_A : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, phase counter and request bookkeeping.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dec_q         <= 1'b0;
      steps_left    <= '0;
      abort_pending <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state) cnt <= '0;
      else if (state != IDLE)  cnt <= cnt + 1'b1;

      if (accept) begin
        dec_q      <= bus.Dec;
        steps_left <= bus.Steps;
      end else if (step_end) begin
        steps_left <= steps_left - 1'b1;
      end

      if (accept || finishing)                abort_pending <= 1'b0;
      else if ((state != IDLE) && bus.Abort)  abort_pending <= 1'b1;

      done_q <= (accept && (bus.Steps == '0)) || finishing;

      if (accept)         aborted_q <= 1'b0;
      else if (finishing) aborted_q <= abort_now && more;
    end
  end

  assign bus.PulsesOut  = pulses;
  assign bus.Busy       = (state != IDLE);
  assign bus.Ready      = (state == IDLE);
  assign bus.Done       = done_q;
  assign bus.Aborted    = aborted_q;
  assign bus.StepStrobe = step_end;
  assign bus.StepsLeft  = steps_left;
  assign bus.state_dbg  = state;

endmodule

// File: doc/dekatron_step_sequencer.md
Name: dekatron_step_sequencer

Overview:
Multi-step successor to the single-step dekatron pulse sender. One request drives a dekatron guide pair through a programmable number of steps, up or down. Guide-phase width and inter-step gap are parametrised to match tube speed. Sits between the sequencing logic, such as IP/AP/counter controllers, and the guide drivers. It gives a start/busy/done handshake, a per-step strobe and a glitch-safe abort.

Parameters:
COUNT_WIDTH, 4, width of step-count request; max steps per request = 2^COUNT_WIDTH-1
PULSE_CYCLES, 1, clocks each guide phase is held (>=1)
GAP_CYCLES, 1, idle clocks (PulsesOut=00) after each step (>=0)

Ports:
Clk  in  1  system clock, all state on rising edge
Rst_n  in  1  synchronous active-low reset
Start  in  1  request; accepted only when Ready=1
Dec  in  1  direction, sampled with Start; 0=increment, 1=decrement
Steps  in  COUNT_WIDTH  step count, sampled with Start
Abort  in  1  stop after current step completes
PulsesOut  out  2  guide drive; 01=right, 10=left, 00=none; 11 never driven
Busy  out  1  high while a request is in progress
Ready  out  1  ~Busy
Done  out  1  one-cycle pulse at request completion
Aborted  out  1  valid with Done; 1 if the request ended by Abort
StepStrobe  out  1  one-cycle pulse in the final cycle of each completed step
StepsLeft  out  COUNT_WIDTH  remaining steps, including the step in progress

Behaviour:
- Reset (Rst_n=0 at edge): state IDLE; PulsesOut=00, Busy=0, Ready=1, Done=0, Aborted=0, StepStrobe=0, StepsLeft=0. Reset mid-step forces 00 on the next edge; a partial step is accepted loss.
- All outputs are registered or decoded directly from state. No combinational path from inputs to PulsesOut.
- FSM states: IDLE, PHASE_A, PHASE_B, GAP. A phase counter counts PULSE_CYCLES or GAP_CYCLES.
- IDLE + Start + Steps>0: latch Dec and Steps, then go to PHASE_A on the next cycle with Busy=1.
- IDLE + Start + Steps=0: no pulses, stay IDLE; Done=1 and Aborted=0 next cycle.
- Step waveform:
  - Increment: PHASE_A=01, PHASE_B=10.
  - Decrement: PHASE_A=10, PHASE_B=01.
  - Each phase lasts PULSE_CYCLES; GAP lasts GAP_CYCLES with 00.
  - GAP_CYCLES=0 skips GAP.
  - Phases are never adjacent to 11; the A->B transition swaps bits in one edge.
- Step completion: StepStrobe=1 in the step's last cycle (last GAP cycle, or last PHASE_B cycle if GAP_CYCLES=0). StepsLeft decrements on the following edge.
- Continue or end after each step:
  - If StepsLeft>1 and no abort is pending: go to PHASE_A.
  - Otherwise go to IDLE; Done=1 for exactly the first IDLE cycle, Busy=0.
- Latency: Start sampled at edge k gives the first PHASE_A cycle at k+1. Total busy cycles = N*(2*PULSE_CYCLES+GAP_CYCLES).
- Back-to-back: Start may be asserted in the Done cycle (Ready=1); the next PHASE_A follows immediately.
- Start while Busy: ignored. Steps and Dec changes while Busy: ignored.
- Abort while Busy:
  - Sets an abort-pending flag; the current step always runs to completion, so the tube is never left between cathodes.
  - Then IDLE with Done=1, Aborted=1; StepsLeft holds the unissued count.
  - Abort in IDLE is ignored.
- Abort and Start in the same IDLE cycle: Start wins; Abort is ignored.
- Aborted clears on the next accepted Start or on reset.

Test Plan:
- Defaults, Start with Steps=3, Dec=0 at cycle 0 -> PulsesOut cycles 1-9 = 01,10,00,01,10,00,01,10,00; StepStrobe at cycles 3,6,9; Done=1 and Busy=0 at cycle 10; PulsesOut never 11.
- Defaults, Steps=2, Dec=1 -> cycles 1-6 = 10,01,00,10,01,00; Done at cycle 7; StepsLeft 2,2,2,1,1,1,0.
- PULSE_CYCLES=3, GAP_CYCLES=0, Steps=1, Dec=0 -> 01 for cycles 1-3, 10 for cycles 4-6, StepStrobe at cycle 6, Done at cycle 7.
- Defaults, Steps=5, Abort pulsed at cycle 4 (mid step 2) -> step 2 completes through cycle 6; cycle 7 Done=1, Aborted=1, StepsLeft=3, PulsesOut=00.
- Steps=0 Start -> no pulses; Done=1 next cycle; Start during Busy ignored; Start in the Done cycle starts the next request the following cycle.
- Rst_n=0 during PHASE_B -> next edge PulsesOut=00, Busy=0, StepsLeft=0; a Start after reset release behaves as a fresh request.
